ccip_tx_arb: RTL

- Transmit-direction counterpart of the CCI-P Rx demultiplexer.
- Merges request streams from NUM_PORTS sub-AFUs (NIC instances) into one upstream CCI-P request channel.
- Buffers each port in a small FIFO and arbitrates round-robin.
- Stamps the port index into the top mdata bits so the Rx demultiplexer can route each response back to its originating NIC.

---
 rtl/ccip_tx_arb_if.sv | 28 ++
 rtl/ccip_tx_arb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ccip_tx_arb_if.sv
// Request-side bundle for ccip_tx_arb: per-port request inputs and back-pressure,
// plus the merged upstream request channel and status counters.
interface ccip_tx_arb_if #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 512,
  parameter int MDATA_W   = 16
);
  logic [NUM_PORTS-1:0]         in_valid;
  logic [NUM_PORTS*DATA_W-1:0]  in_data;
  logic [NUM_PORTS*MDATA_W-1:0] in_mdata;
  logic [NUM_PORTS-1:0]         in_almfull;
  logic                         up_almfull;
  logic                         out_valid;
  logic [DATA_W-1:0]            out_data;
  logic [MDATA_W-1:0]           out_mdata;
  logic [NUM_PORTS-1:0]         overflow;
  logic [NUM_PORTS*32-1:0]      grant_cnt;

  modport slave (
    input  in_valid, in_data, in_mdata, up_almfull,
    output in_almfull, out_valid, out_data, out_mdata, overflow, grant_cnt
  );

  modport master (
    output in_valid, in_data, in_mdata, up_almfull,
    input  in_almfull, out_valid, out_data, out_mdata, overflow, grant_cnt
  );
endinterface

// File: rtl/ccip_tx_arb.sv
// Merges NUM_PORTS sub-AFU request streams into one upstream CCI-P request channel:
// per-port FIFOs, round-robin arbitration, port index stamped into the top mdata bits.
module ccip_tx_arb #(
  parameter int NUM_PORTS     = 2,
  parameter int PORT_ID_W     = 1,
  parameter int DATA_W        = 512,
  parameter int MDATA_W       = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALMFULL_SLACK = 3
) (
  input logic          clk,
  input logic          reset_n,
  ccip_tx_arb_if.slave bus
);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int ENT_W  = DATA_W + MDATA_W;
  localparam int THRESH = FIFO_DEPTH - ALMFULL_SLACK;

  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  logic [ENT_W-1:0] r_mem   [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]    r_wptr  [NUM_PORTS];
  logic [AW-1:0]    r_rptr  [NUM_PORTS];
  logic [AW:0]      r_count [NUM_PORTS];
  logic [AW:0]      w_count_nxt [NUM_PORTS];

  logic [NUM_PORTS-1:0]       w_push, w_pop, w_full, w_nempty, w_ovf_set;
  logic [NUM_PORTS-1:0]       r_almfull, r_overflow;
  logic [NUM_PORTS-1:0][31:0] r_grant_cnt;

  logic [IDX_W-1:0]   r_rr_ptr, w_win;
  logic               w_grant;
  logic [ENT_W-1:0]   w_head;
  logic [MDATA_W-1:0] w_head_mdata, w_tag_mdata;

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [MDATA_W-1:0] r_out_mdata;

  // Release is synchronised so every flop below leaves reset on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IDX_W'(s);
  endfunction

  always_comb begin
    w_grant = 1'b0;
    w_win   = r_rr_ptr;
    w_pop   = '0;
    if (!bus.up_almfull) begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        if (!w_grant && w_nempty[f_wrap(r_rr_ptr, k)]) begin
          w_grant = 1'b1;
          w_win   = f_wrap(r_rr_ptr, k);
        end
      end
      if (w_grant) w_pop[w_win] = 1'b1;
    end
  end

  // A full FIFO that is popped this cycle still has room for the incoming write.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_full[i]      = (r_count[i] == (AW+1)'(FIFO_DEPTH));
      w_nempty[i]    = (r_count[i] != '0);
      w_push[i]      = bus.in_valid[i] && (!w_full[i] || w_pop[i]);
      w_ovf_set[i]   = bus.in_valid[i] && w_full[i] && !w_pop[i];
      w_count_nxt[i] = r_count[i] + {{AW{1'b0}}, w_push[i]} - {{AW{1'b0}}, w_pop[i]};
    end
  end

  always_comb begin
    w_head       = r_mem[w_win][r_rptr[w_win]];
    w_head_mdata = w_head[MDATA_W-1:0];
    w_tag_mdata  = w_head_mdata;
    w_tag_mdata[MDATA_W-1 -: PORT_ID_W] = PORT_ID_W'(w_win);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_push[i])
        r_mem[i][r_wptr[i]] <= {bus.in_data[i*DATA_W +: DATA_W], bus.in_mdata[i*MDATA_W +: MDATA_W]};
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
      r_almfull   <= '0;
      r_overflow  <= '0;
      r_grant_cnt <= '0;
      r_rr_ptr    <= IDX_W'(NUM_PORTS - 1);
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mdata <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
        if (w_pop[i]) begin
          r_rptr[i]      <= r_rptr[i] + AW'(1);
          r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        end
        r_count[i]   <= w_count_nxt[i];
        r_almfull[i] <= (w_count_nxt[i] >= (AW+1)'(THRESH));
        if (w_ovf_set[i]) r_overflow[i] <= 1'b1;
      end
      r_out_valid <= w_grant;
      if (w_grant) begin
        r_rr_ptr    <= w_win;
        r_out_data  <= w_head[ENT_W-1 -: DATA_W];
        r_out_mdata <= w_tag_mdata;
      end
    end
  end

  assign bus.in_almfull = r_almfull;
  assign bus.overflow   = r_overflow;
  assign bus.grant_cnt  = r_grant_cnt;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_mdata  = r_out_mdata;
endmodule
